// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALU execute stage, single-cycle logic ops plus optional
// iterative mul/div (enable with `define MULDIV_EN), valid/ready on both sides.
//   clk, reset (async, active-low)
//   in_valid/in_ready, a, b, opcode, save : operand side
//   out_valid/out_ready, alu_out, carry_out : result side
//   data_out : save register, busy : mul/div iterating
`default_nettype none

module alu_exec_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  input  logic             save,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic [WIDTH-1:0] data_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] alu_q;
  logic             carry_q;
  logic [WIDTH-1:0] data_q;

  logic             accept;
  logic [WIDTH-1:0] res_s;
  logic             cy_s;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   dif_w;

  assign in_ready  = (state_q == IDLE) |
                     ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign alu_out   = alu_q;
  assign carry_out = carry_q;
  assign data_out  = data_q;
  assign busy      = (state_q == EXEC);

  // Single-cycle result, computed from the live inputs at accept.
  always_comb begin
    sum_w = {1'b0, a} + {1'b0, b};
    dif_w = {1'b0, a} - {1'b0, b};
    res_s = '0;
    cy_s  = 1'b0;
    unique case (opcode)
      3'b000: begin
        res_s = sum_w[WIDTH-1:0];
        cy_s  = sum_w[WIDTH];
      end
      3'b001: begin
        res_s = dif_w[WIDTH-1:0];
        cy_s  = dif_w[WIDTH];
      end
      3'b010: res_s = a & b;
      3'b011: res_s = a | b;
      3'b100: res_s = a ^ b;
      3'b111: begin
        res_s[0] = (a == b);
        res_s[1] = (a > b);
        res_s[2] = (a < b);
      end
      default: begin
`ifdef MULDIV_EN
        cy_s = 1'b0;
`else
        // mul/div not built: flag as unsupported
        cy_s = 1'b1;
`endif
      end
    endcase
  end

`ifdef MULDIV_EN
  localparam int CW = $clog2(WIDTH);

  logic                 is_md;
  logic                 div_q;
  logic                 save_q;
  logic [WIDTH-1:0]     opa_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CW-1:0]        cnt_q;

  logic [WIDTH:0]       msum;
  logic [WIDTH:0]       dsh;
  logic [WIDTH-1:0]     ddif;
  logic [2*WIDTH-1:0]   acc_n;
  logic [WIDTH-1:0]     md_res;
  logic                 md_cy;

  assign is_md = (opcode == 3'b101) | (opcode == 3'b110);

  // acc_q holds {hi, lo}. mul: hi = partial product, lo = multiplier
  // shifting out. div: hi = remainder, lo = dividend shifting into
  // quotient. opa_q is the multiplicand or the divisor.
  always_comb begin
    msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
           (acc_q[0] ? {1'b0, opa_q} : '0);
    dsh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ddif = dsh[WIDTH-1:0] - opa_q;
    if (div_q) begin
      if (dsh >= {1'b0, opa_q}) begin
        acc_n = {ddif, acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = {dsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_n = {msum, acc_q[WIDTH-1:1]};
    end
    md_res = acc_n[WIDTH-1:0];
    // divide by zero naturally yields an all-ones quotient
    md_cy  = div_q ? (opa_q == '0)
                   : (|acc_n[2*WIDTH-1:WIDTH]);
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      alu_q       <= '0;
      carry_q     <= 1'b0;
      data_q      <= '0;
`ifdef MULDIV_EN
      div_q       <= 1'b0;
      save_q      <= 1'b0;
      opa_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
`endif
    end else if (accept) begin
`ifdef MULDIV_EN
      if (is_md) begin
        state_q     <= EXEC;
        out_valid_q <= 1'b0;
        cnt_q       <= '0;
        div_q       <= opcode[1];
        save_q      <= save;
        opa_q       <= opcode[1] ? b : a;
        acc_q       <= {{WIDTH{1'b0}},
                        (opcode[1] ? a : b)};
      end else
`endif
      begin
        state_q     <= DONE;
        out_valid_q <= 1'b1;
        alu_q       <= res_s;
        carry_q     <= cy_s;
        if (save) data_q <= res_s;
      end
    end else begin
      unique case (state_q)
`ifdef MULDIV_EN
        EXEC: begin
          acc_q <= acc_n;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            alu_q       <= md_res;
            carry_q     <= md_cy;
            cnt_q       <= '0;
            if (save_q) data_q <= md_res;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: randomized self-checking bench for alu_exec_unit
// against an arithmetic reference model (WIDTH=8).
`timescale 1ns/1ps

module tb_alu_exec_unit;
  localparam int W = 8;
`ifdef MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   opcode;
  logic         save;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_out;
  logic         carry_out;
  logic [W-1:0] data_out;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_data;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .save(save),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .carry_out(carry_out),
    .data_out(data_out), .busy(busy)
  );

  // Reference: plain integer arithmetic. lat = edges from accept until
  // out_valid is seen high (0 = already high the cycle after accept).
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [2:0] op, output logic [W-1:0] r,
                                output logic c, output int lat);
    int unsigned ix, iy, t;
    ix = x; iy = y; r = '0; c = 1'b0; lat = 0;
    case (op)
      3'd0: begin t = ix + iy; r = W'(t); c = (t >= 256); end
      3'd1: begin r = W'(ix - iy); c = (ix < iy); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin
        if (MD) begin t = ix * iy; r = W'(t); c = ((t >> W) != 0); lat = W; end
        else c = 1'b1;
      end
      3'd6: begin
        if (MD) begin
          lat = W;
          if (iy == 0) begin r = '1; c = 1'b1; end
          else r = W'(ix / iy);
        end else c = 1'b1;
      end
      default: r = W'({ix < iy, ix > iy, ix == iy});
    endcase
  endfunction

  function automatic logic [2:0] rand_single();
    int k;
    k = $urandom_range(0, 5);
    return (k == 5) ? 3'd7 : 3'(k);
  endfunction

  // Drives one transaction from idle and reports what it observed.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2:0] op, input logic sv,
                        output logic [W-1:0] r, output logic c,
                        output logic [W-1:0] dout, output int lat,
                        output int bcnt, output logic rdy_seen);
    @(negedge clk);
    a = x; b = y; opcode = op; save = sv;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    opcode = 3'($urandom); save = 1'($urandom);
    lat = 0; bcnt = 0; rdy_seen = 1'b0;
    while (!out_valid && lat < 64) begin
      if (busy) bcnt++;
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    r = alu_out; c = carry_out; dout = data_out;
    if (busy) bcnt += 1000;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; opcode = '0; save = 1'b0;
    exp_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    checks++; if (alu_out !== 8'h00) begin errors++; $display("FAIL reset alu_out: got %h want 00", alu_out); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset carry: got %b want 0", carry_out); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset data_out: got %h want 00", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic [W-1:0] ta [7] = '{8'd5, 8'd5, 8'd3, 8'd5, 8'd5, 8'd5, 8'd5};
    logic [W-1:0] tb [7] = '{8'd3, 8'd3, 8'd5, 8'd3, 8'd3, 8'd3, 8'd3};
    logic [2:0]   to [7] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    logic [W-1:0] tr [7] = '{8'h08, 8'h02, 8'hFE, 8'h01, 8'h07, 8'h06, 8'h02};
    logic         tc [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [W-1:0] r, d; logic c, rs; int lat, bc;
    for (int i = 0; i < 7; i++) begin
      run_op(ta[i], tb[i], to[i], 1'b0, r, c, d, lat, bc, rs);
      checks++; if (r !== tr[i]) begin errors++; $display("FAIL single[%0d] result: got %h want %h", i, r, tr[i]); end
      checks++; if (c !== tc[i]) begin errors++; $display("FAIL single[%0d] carry: got %b want %b", i, c, tc[i]); end
      checks++; if (lat !== 0) begin errors++; $display("FAIL single[%0d] latency: got %0d want 0", i, lat); end
      checks++; if (bc !== 0) begin errors++; $display("FAIL single[%0d] busy: got %0d want 0", i, bc); end
    end
  endtask

  task automatic test_muldiv();
    logic [W-1:0] ta [4] = '{8'd5, 8'h10, 8'd5, 8'd5};
    logic [W-1:0] tb [4] = '{8'd3, 8'h10, 8'd3, 8'd0};
    logic [2:0]   to [4] = '{3'd5, 3'd5, 3'd6, 3'd6};
    logic [W-1:0] tr [4] = '{8'h0F, 8'h00, 8'h01, 8'hFF};
    logic         tc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] r, d, er; logic c, rs, ec; int lat, bc, el;
    for (int i = 0; i < 4; i++) begin
      er = MD ? tr[i] : 8'h00;
      ec = MD ? tc[i] : 1'b1;
      el = MD ? W : 0;
      run_op(ta[i], tb[i], to[i], 1'b0, r, c, d, lat, bc, rs);
      checks++; if (r !== er) begin errors++; $display("FAIL muldiv[%0d] result: got %h want %h", i, r, er); end
      checks++; if (c !== ec) begin errors++; $display("FAIL muldiv[%0d] carry: got %b want %b", i, c, ec); end
      checks++; if (lat !== el) begin errors++; $display("FAIL muldiv[%0d] latency: got %0d want %0d", i, lat, el); end
      checks++; if (bc !== el) begin errors++; $display("FAIL muldiv[%0d] busy cycles: got %0d want %0d", i, bc, el); end
      checks++; if (rs !== 1'b0) begin errors++; $display("FAIL muldiv[%0d] in_ready while busy: got %b want 0", i, rs); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, r, d, er; logic [2:0] op; logic sv, c, rs, ec;
    int lat, bc, el;
    for (int i = 0; i < 60; i++) begin
      x = W'($urandom); y = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      op = 3'($urandom); sv = 1'($urandom);
      model(x, y, op, er, ec, el);
      if (sv) exp_data = er;
      run_op(x, y, op, sv, r, c, d, lat, bc, rs);
      checks++; if (r !== er) begin errors++; $display("FAIL rand[%0d] op%0d %h,%h result: got %h want %h", i, op, x, y, r, er); end
      checks++; if (c !== ec) begin errors++; $display("FAIL rand[%0d] op%0d carry: got %b want %b", i, op, c, ec); end
      checks++; if (lat !== el) begin errors++; $display("FAIL rand[%0d] op%0d latency: got %0d want %0d", i, op, lat, el); end
      checks++; if (d !== exp_data) begin errors++; $display("FAIL rand[%0d] data_out: got %h want %h", i, d, exp_data); end
    end
  endtask

  task automatic test_save();
    logic [W-1:0] r, d; logic c, rs; int lat, bc;
    run_op(8'd5, 8'd3, 3'd4, 1'b1, r, c, d, lat, bc, rs);
    exp_data = 8'h06;
    checks++; if (d !== 8'h06) begin errors++; $display("FAIL save xor data_out: got %h want 06", d); end
    run_op(8'd1, 8'd1, 3'd0, 1'b0, r, c, d, lat, bc, rs);
    checks++; if (r !== 8'h02) begin errors++; $display("FAIL save add result: got %h want 02", r); end
    checks++; if (d !== 8'h06) begin errors++; $display("FAIL save hold data_out: got %h want 06", d); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] x, y, er; logic [2:0] op; logic ec; int el;
    @(negedge clk);
    a = 8'd200; b = 8'd100; opcode = 3'd0; save = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); opcode = rand_single();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp[%0d] out_valid: got %b want 1", i, out_valid); end
      checks++; if (alu_out !== 8'h2C) begin errors++; $display("FAIL bp[%0d] alu_out: got %h want 2C", i, alu_out); end
      checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL bp[%0d] carry: got %b want 1", i, carry_out); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp[%0d] in_ready: got %b want 0", i, in_ready); end
    end
    x = W'($urandom); y = W'($urandom); op = rand_single();
    model(x, y, op, er, ec, el);
    a = x; b = y; opcode = op; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp release in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp next out_valid: got %b want 1", out_valid); end
    checks++; if (alu_out !== er) begin errors++; $display("FAIL bp next result: got %h want %h", alu_out, er); end
    checks++; if (carry_out !== ec) begin errors++; $display("FAIL bp next carry: got %b want %b", carry_out, ec); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x, y, er; logic [2:0] op; logic ec; int el;
    @(negedge clk);
    out_ready = 1'b1; save = 1'b0;
    x = W'($urandom); y = W'($urandom); op = rand_single();
    a = x; b = y; opcode = op; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      model(x, y, op, er, ec, el);
      @(negedge clk);
      x = W'($urandom); y = W'($urandom); op = rand_single();
      a = x; b = y; opcode = op; in_valid = (i != 7);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b[%0d] out_valid: got %b want 1", i, out_valid); end
      checks++; if (alu_out !== er) begin errors++; $display("FAIL b2b[%0d] result: got %h want %h", i, alu_out, er); end
      checks++; if (carry_out !== ec) begin errors++; $display("FAIL b2b[%0d] carry: got %b want %b", i, carry_out, ec); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    logic [W-1:0] r, d; logic c, rs; int lat, bc, seen;
    @(negedge clk);
    a = 8'd5; b = 8'd3; opcode = 3'd5; save = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_data = '0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midop out_valid: got %b want 0", out_valid); end
    checks++; if (alu_out !== 8'h00) begin errors++; $display("FAIL midop alu_out: got %h want 00", alu_out); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL midop carry: got %b want 0", carry_out); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midop data_out: got %h want 00", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midop busy: got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midop stale activity: got %0d cycles want 0", seen); end
    run_op(8'd1, 8'd2, 3'd0, 1'b0, r, c, d, lat, bc, rs);
    checks++; if (r !== 8'h03) begin errors++; $display("FAIL midop add result: got %h want 03", r); end
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL midop data after: got %h want 00", d); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_muldiv();
    test_save();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
